darkbus_arbiter: RTL
====================

Name: darkbus_arbiter

Overview:
- Two-requester arbiter sharing one single-ported darkbus memory slave (boot ROM / OCRAM) between instruction fetch (M0) and data load (M1).
- Sits between the core's two bus masters and the memory's consumer port.
- Serialises transactions, routes returned data and valid back to the owner, and round-robins under contention.
- A timeout watchdog answers with a NOP word and an error flag if the slave never returns valid.

Parameters:
- AW, 32: address width.
- DW, 32: data width.
- TIMEOUT, 15: WAIT-state cycles without S_VALID before forced completion (1..255).
- NOP_WORD, 32'h0000_0013: data returned on timeout (addi x0,x0,0).

Ports:
- XCLK  in  1  system clock, rising edge.
- XRES  in  1  asynchronous, active-low reset.
- M0_EN  in  1  fetch request; held until M0_VALID.
- M0_ADDR  in  AW  fetch byte address.
- M0_DATA  out  DW  fetch read data; meaningful when M0_VALID=1.
- M0_VALID  out  1  one-cycle completion pulse.
- M0_ERR  out  1  with M0_VALID: completion was a timeout.
- M1_EN, M1_ADDR, M1_DATA, M1_VALID, M1_ERR: same as M0, for the data port.
- S_EN  out  1  one-cycle request pulse to the slave.
- S_ADDR  out  AW  slave address; stable from S_EN until completion.
- S_DATA  in  DW  slave read data.
- S_VALID  in  1  slave completion.
- OWNER  out  1  current/last granted requester.
- BUSY  out  1  high when the FSM is not in IDLE.

Behaviour:
- Reset (XRES=0, async):
  - FSM=IDLE, LAST=1, so M0 wins the first contention.
  - All outputs 0: S_EN, S_ADDR, Mx_DATA, Mx_VALID, Mx_ERR, OWNER, BUSY. Timeout counter=0.
  - Reset mid-transaction aborts it silently; a later stale S_VALID is ignored.
- FSM: IDLE -> WAIT -> RESP -> IDLE. All outputs registered.
- IDLE:
  - If any Mx_EN: choose winner W, register OWNER=W, S_ADDR=Mx_ADDR[W], S_EN=1, counter=0, go WAIT.
  - Arbitration: if only one requester, it wins. If both, winner = !LAST. LAST<=W on grant.
- WAIT:
  - S_EN is high only in the first WAIT cycle.
  - Counter increments each cycle.
  - On S_VALID: latch S_DATA into Mx_DATA[OWNER], ERR=0, go RESP.
  - Else if counter==TIMEOUT-1: data=NOP_WORD, ERR=1, go RESP.
  - S_VALID in the same cycle as timeout: S_VALID wins, ERR=0.
- RESP:
  - Mx_VALID[OWNER]=1 for exactly one cycle; the other port's VALID stays 0.
  - Requests are not sampled in RESP; go IDLE.
  - Mx_DATA holds its value until that port's next completion.
- Latency with a 1-cycle slave: EN to VALID = 3 cycles. Throughput is one transaction per 4 cycles.
- Requester contract: drop or change EN/ADDR only in the cycle after its VALID.
- A requester that drops EN during WAIT still receives its VALID; it ignores it.
- S_VALID seen in IDLE or RESP is ignored.
- Mx_ADDR is passed through unmodified; no alignment check.
- BUSY = (state != IDLE).

Optional Feature:
- Macro: DARKBUS_ARB_FIXED_PRIO_EN.
- Defined: fixed priority, M0 always wins contention. LAST still updates but is unused.
- Undefined (default): round-robin as above.

Decomposition:
- Package darkbus_pkg:
  - arb_state_t enum {IDLE, WAIT, RESP}
  - owner_t (logic [0:0])
  - localparam DARK_NOP = 32'h0000_0013
- Sub-module darkarb_pick: combinational 2-way winner select from EN vector and LAST, fixed-priority variant under the macro.
- Everything else (FSM, counter, response registers) lives in darkbus_arbiter.

Test Plan:
1. Single requester: M0_EN=1, ADDR=0x0000_0010; 1-cycle slave returns 0xDEAD_BEEF -> S_EN pulse 1 cycle after EN, S_ADDR=0x10, M0_VALID at cycle 3 with DATA=0xDEAD_BEEF, ERR=0, M1_VALID=0.
2. Contention: M0 and M1 both requesting continuously out of reset -> grants alternate M0,M1,M0,M1 at 4-cycle spacing. With DARKBUS_ARB_FIXED_PRIO_EN defined, M0 is granted every time.
3. Timeout: slave never asserts S_VALID, TIMEOUT=15 -> M1_VALID after 15 WAIT cycles with DATA=0x0000_0013, ERR=1; next request proceeds normally.
4. Boundary: S_VALID arrives on the cycle counter==TIMEOUT-1 -> slave data delivered, ERR=0.
5. Reset mid-WAIT: deassert XRES during WAIT, release, then slave pulses S_VALID -> no Mx_VALID, BUSY=0, OWNER=0; next contention grants M0.
6. Stale and abandoned: S_VALID pulsed in IDLE -> ignored. M0 drops EN during WAIT -> M0_VALID still pulses once, with no re-issue.

Source files
------------

// File: rtl/darkbus_arbiter_pkg.sv
// Shared types and constants for the darkbus two-master arbiter.
package darkbus_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } arb_state_t;

   typedef logic [0:0] owner_t;

   // addi x0,x0,0 -- harmless filler returned when the slave never answers
   localparam logic [31:0] DARK_NOP = 32'h0000_0013;

endpackage

// File: rtl/darkbus_arbiter_pick.sv
// Two-way winner select for darkbus_arbiter.
// Define DARKBUS_ARB_FIXED_PRIO_EN for fixed M0 priority instead of round-robin.
module darkarb_pick
   import darkbus_pkg::*;
(
   input  logic [1:0] req_s,
   input  owner_t     last_s,
   output logic       grant_s,
   output owner_t     winner_s
);

   // Pick the requester that gets the bus this cycle
   always_comb begin
      grant_s  = |req_s;
      winner_s = 1'b0;
`ifdef DARKBUS_ARB_FIXED_PRIO_EN
      if (req_s[0]) begin
         winner_s = 1'b0;
      end else if (req_s[1]) begin
         winner_s = 1'b1;
      end else begin
         winner_s = 1'b0;
      end
`else
      case (req_s)
         2'b01:   winner_s = 1'b0;
         2'b10:   winner_s = 1'b1;
         2'b11:   winner_s = ~last_s;
         default: winner_s = 1'b0;
      endcase
`endif
   end

endmodule

// File: rtl/darkbus_arbiter.sv
// Shares one single-ported darkbus slave between fetch (M0) and load (M1) masters.
// Optional DARKBUS_ARB_FIXED_PRIO_EN selects fixed M0 priority in darkarb_pick.
module darkbus_arbiter
   import darkbus_pkg::*;
#(
   parameter int              AW       = 32,
   parameter int              DW       = 32,
   parameter int              TIMEOUT  = 15,
   parameter logic [DW-1:0]   NOP_WORD = DW'(DARK_NOP)
) (
   input  logic          XCLK,
   input  logic          XRES,
   input  logic          M0_EN,
   input  logic [AW-1:0] M0_ADDR,
   output logic [DW-1:0] M0_DATA,
   output logic          M0_VALID,
   output logic          M0_ERR,
   input  logic          M1_EN,
   input  logic [AW-1:0] M1_ADDR,
   output logic [DW-1:0] M1_DATA,
   output logic          M1_VALID,
   output logic          M1_ERR,
   output logic          S_EN,
   output logic [AW-1:0] S_ADDR,
   input  logic [DW-1:0] S_DATA,
   input  logic          S_VALID,
   output logic          OWNER,
   output logic          BUSY
);

   localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);

   arb_state_t    state_r,    state_nxt_s;
   owner_t        owner_r,    owner_nxt_s;
   owner_t        last_r,     last_nxt_s;
   logic [7:0]    cnt_r,      cnt_nxt_s;
   logic          s_en_r,     s_en_nxt_s;
   logic [AW-1:0] s_addr_r,   s_addr_nxt_s;
   logic [DW-1:0] m0_data_r,  m0_data_nxt_s;
   logic [DW-1:0] m1_data_r,  m1_data_nxt_s;
   logic          m0_valid_r, m0_valid_nxt_s;
   logic          m1_valid_r, m1_valid_nxt_s;
   logic          m0_err_r,   m0_err_nxt_s;
   logic          m1_err_r,   m1_err_nxt_s;
   logic          busy_r;

   logic          grant_s;
   owner_t        winner_s;
   logic          done_s;
   logic          done_err_s;
   logic [DW-1:0] done_data_s;

   darkarb_pick u_pick (
      .req_s    ({M1_EN, M0_EN}),
      .last_s   (last_r),
      .grant_s  (grant_s),
      .winner_s (winner_s)
   );

   // Next-state logic: grant in IDLE, wait for slave or timeout, one-cycle response
   always_comb begin
      state_nxt_s  = state_r;
      owner_nxt_s  = owner_r;
      last_nxt_s   = last_r;
      cnt_nxt_s    = cnt_r;
      s_en_nxt_s   = 1'b0;
      s_addr_nxt_s = s_addr_r;
      done_s       = 1'b0;
      done_err_s   = 1'b0;
      done_data_s  = S_DATA;
      case (state_r)
         IDLE: begin
            if (grant_s) begin
               state_nxt_s  = WAIT;
               owner_nxt_s  = winner_s;
               last_nxt_s   = winner_s;
               s_addr_nxt_s = (winner_s == 1'b1) ? M1_ADDR : M0_ADDR;
               s_en_nxt_s   = 1'b1;
               cnt_nxt_s    = 8'd0;
            end else begin
               state_nxt_s  = IDLE;
            end
         end
         WAIT: begin
            cnt_nxt_s = cnt_r + 8'd1;
            // A slave answer in the timeout cycle still counts as a real answer
            if (S_VALID) begin
               state_nxt_s = RESP;
               done_s      = 1'b1;
               done_err_s  = 1'b0;
               done_data_s = S_DATA;
            end else if (cnt_r == TIMEOUT_LAST) begin
               state_nxt_s = RESP;
               done_s      = 1'b1;
               done_err_s  = 1'b1;
               done_data_s = NOP_WORD;
            end else begin
               state_nxt_s = WAIT;
            end
         end
         RESP: begin
            state_nxt_s = IDLE;
         end
         default: begin
            state_nxt_s = IDLE;
         end
      endcase
   end

   // Route a completion to the owning port; data of the other port is kept
   always_comb begin
      m0_data_nxt_s  = m0_data_r;
      m1_data_nxt_s  = m1_data_r;
      m0_valid_nxt_s = 1'b0;
      m1_valid_nxt_s = 1'b0;
      m0_err_nxt_s   = 1'b0;
      m1_err_nxt_s   = 1'b0;
      if (done_s && (owner_r == 1'b0)) begin
         m0_data_nxt_s  = done_data_s;
         m0_valid_nxt_s = 1'b1;
         m0_err_nxt_s   = done_err_s;
      end else if (done_s && (owner_r == 1'b1)) begin
         m1_data_nxt_s  = done_data_s;
         m1_valid_nxt_s = 1'b1;
         m1_err_nxt_s   = done_err_s;
      end else begin
         m0_valid_nxt_s = 1'b0;
         m1_valid_nxt_s = 1'b0;
      end
   end

   // State and output registers; LAST resets to 1 so M0 wins the first contention
   always_ff @(posedge XCLK or negedge XRES) begin
      if (!XRES) begin
         state_r    <= IDLE;
         owner_r    <= 1'b0;
         last_r     <= 1'b1;
         cnt_r      <= 8'd0;
         s_en_r     <= 1'b0;
         s_addr_r   <= {AW{1'b0}};
         m0_data_r  <= {DW{1'b0}};
         m1_data_r  <= {DW{1'b0}};
         m0_valid_r <= 1'b0;
         m1_valid_r <= 1'b0;
         m0_err_r   <= 1'b0;
         m1_err_r   <= 1'b0;
         busy_r     <= 1'b0;
      end else begin
         state_r    <= state_nxt_s;
         owner_r    <= owner_nxt_s;
         last_r     <= last_nxt_s;
         cnt_r      <= cnt_nxt_s;
         s_en_r     <= s_en_nxt_s;
         s_addr_r   <= s_addr_nxt_s;
         m0_data_r  <= m0_data_nxt_s;
         m1_data_r  <= m1_data_nxt_s;
         m0_valid_r <= m0_valid_nxt_s;
         m1_valid_r <= m1_valid_nxt_s;
         m0_err_r   <= m0_err_nxt_s;
         m1_err_r   <= m1_err_nxt_s;
         busy_r     <= (state_nxt_s != IDLE);
      end
   end

   assign M0_DATA  = m0_data_r;
   assign M0_VALID = m0_valid_r;
   assign M0_ERR   = m0_err_r;
   assign M1_DATA  = m1_data_r;
   assign M1_VALID = m1_valid_r;
   assign M1_ERR   = m1_err_r;
   assign S_EN     = s_en_r;
   assign S_ADDR   = s_addr_r;
   assign OWNER    = owner_r;
   assign BUSY     = busy_r;

endmodule
